// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 program store.
//   TD4_AW/IW/NW : address, instruction and load-nibble widths
//   ld_state_e   : loader state machine states
//   TD4_OP_*/TD4_IMM_* : bit positions of the op and imm fields within an instruction
package td4_pkg;
  localparam int unsigned TD4_AW    = 4;
  localparam int unsigned TD4_IW    = 8;
  localparam int unsigned TD4_NW    = 4;
  localparam int unsigned TD4_DEPTH = 1 << TD4_AW;

  localparam int unsigned TD4_OP_MSB  = TD4_IW - 1;
  localparam int unsigned TD4_OP_LSB  = TD4_IW / 2;
  localparam int unsigned TD4_IMM_MSB = TD4_IW / 2 - 1;
  localparam int unsigned TD4_IMM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_LO,
    LOAD_HI,
    RUN
  } ld_state_e;
endpackage

// File: rtl/td4_imem_array.sv
// Flop-based instruction memory, 2**AW words of IW bits.
//   clk   : clock
//   clr   : synchronous active-high clear of every word
//   we    : write enable; waddr/wdata written on posedge
//   raddr : asynchronous read address; rdata follows it combinationally
module td4_imem_array
  import td4_pkg::*;
#(
  parameter int unsigned AW = TD4_AW,
  parameter int unsigned IW = TD4_IW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/td4_prog_loader.sv
// TD4 program store and loader.
//   clk, rst             : clock, synchronous active-high reset
//   load_start/load_end  : begin a (re)load at address 0 / finish early and run
//   nib_valid/nib_data   : nibble load port, low nibble of each byte first
//   nib_ready            : nibble accepted this cycle when nib_valid is high
//   pc                   : fetch address
//   op/imm               : instruction fields of mem[pc], forced to zero while not running
//   run                  : program valid, core may execute
//   prog_len             : bytes written since the last load_start
module td4_prog_loader
  import td4_pkg::*;
#(
  parameter int unsigned AW = TD4_AW,
  parameter int unsigned IW = TD4_IW,
  parameter int unsigned NW = TD4_NW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic            load_end,
  input  logic            nib_valid,
  input  logic [NW-1:0]   nib_data,
  output logic            nib_ready,
  input  logic [AW-1:0]   pc,
  output logic [IW/2-1:0] op,
  output logic [IW/2-1:0] imm,
  output logic            run,
  output logic [AW:0]     prog_len
);
  ld_state_e     state, state_nxt;
  logic [AW-1:0] wptr;
  logic [NW-1:0] lo_hold;
  logic          xfer;
  logic          we;
  logic [IW-1:0] rdata;

  assign xfer = nib_valid & nib_ready;
  assign we   = xfer & (state == LOAD_HI);

  td4_imem_array #(
    .AW (AW),
    .IW (IW)
  ) u_imem (
    .clk   (clk),
    .clr   (rst),
    .we    (we),
    .waddr (wptr),
    .wdata ({nib_data, lo_hold}),
    .raddr (pc),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // load_start dominates in every state; load_end only ends a load on a byte boundary.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load_start) state_nxt = LOAD_LO;
      LOAD_LO: begin
        if (load_start)    state_nxt = LOAD_LO;
        else if (load_end) state_nxt = RUN;
        else if (xfer)     state_nxt = LOAD_HI;
      end
      LOAD_HI: begin
        if (load_start) state_nxt = LOAD_LO;
        else if (xfer)  state_nxt = (wptr == '1) ? RUN : LOAD_LO;
      end
      RUN:     if (load_start) state_nxt = LOAD_LO;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    nib_ready = ((state == LOAD_LO) & ~load_start & ~load_end) |
                ((state == LOAD_HI) & ~load_start);
    run       = (state == RUN);
    op        = run ? rdata[IW-1:IW/2] : '0;
    imm       = run ? rdata[IW/2-1:0]  : '0;
  end

  // wptr wraps to 0 naturally after the last byte, ready for the next load.
  always_ff @(posedge clk) begin
    if (rst || load_start) begin
      wptr     <= '0;
      lo_hold  <= '0;
      prog_len <= '0;
    end else if (xfer && state == LOAD_LO) begin
      lo_hold <= nib_data;
    end else if (we) begin
      wptr     <= wptr + 1'b1;
      prog_len <= prog_len + 1'b1;
    end
  end
endmodule

// File: tb/tb_td4_prog_loader.sv
module tb_td4_prog_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_start = 1'b0;
  logic       load_end = 1'b0;
  logic       nib_valid = 1'b0;
  logic [3:0] nib_data = 4'h0;
  logic       nib_ready;
  logic [3:0] pc = 4'h0;
  logic [3:0] op;
  logic [3:0] imm;
  logic       run;
  logic [4:0] prog_len;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a byte array plus "loading", "low nibble held" and a byte count.
  bit         m_known = 1'b0;
  bit         m_loading, m_half, m_run;
  int         m_len;
  logic [3:0] m_lo;
  logic [7:0] m_mem [16];

  always #5 clk = ~clk;

  td4_prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_end   (load_end),
    .nib_valid  (nib_valid),
    .nib_data   (nib_data),
    .nib_ready  (nib_ready),
    .pc         (pc),
    .op         (op),
    .imm        (imm),
    .run        (run),
    .prog_len   (prog_len)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit st, input bit en, input bit v,
                      input logic [3:0] d, input logic [3:0] p);
    bit         rdy;
    logic [7:0] eb;
    @(negedge clk);
    rst = r; load_start = st; load_end = en; nib_valid = v; nib_data = d; pc = p;
    #1;
    rdy = m_loading && !st && !(!m_half && en);
    if (m_known) begin
      eb = m_run ? m_mem[p] : 8'h00;
      chk("nib_ready", {7'b0, nib_ready}, {7'b0, rdy});
      chk("run", {7'b0, run}, {7'b0, m_run});
      chk("op", {4'b0, op}, {4'b0, eb[7:4]});
      chk("imm", {4'b0, imm}, {4'b0, eb[3:0]});
      chk("prog_len", {3'b0, prog_len}, 8'(m_len));
    end
    @(posedge clk);
    if (r) begin
      m_known = 1'b1; m_loading = 0; m_half = 0; m_run = 0; m_len = 0; m_lo = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    end else if (st) begin
      m_loading = 1; m_half = 0; m_run = 0; m_len = 0;
    end else if (m_loading && !m_half && en) begin
      m_loading = 0; m_run = 1;
    end else if (v && rdy) begin
      if (!m_half) begin
        m_lo = d; m_half = 1;
      end else begin
        m_mem[m_len] = {d, m_lo};
        m_len++;
        m_half = 0;
        if (m_len == 16) begin m_loading = 0; m_run = 1; end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'($urandom), 4'($urandom));
  endtask
  task automatic start();  step(0, 1, 0, 0, 4'($urandom), 4'($urandom)); endtask
  task automatic finish_ld(); step(0, 0, 1, 0, 4'($urandom), 4'($urandom)); endtask
  task automatic reset1(); step(1, 0, 0, 0, 4'($urandom), 4'($urandom)); endtask
  task automatic send(input logic [3:0] d); step(0, 0, 0, 1, d, 4'($urandom)); endtask
  task automatic dump();
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 4'($urandom), 4'(i));
  endtask
  // Reads the DUT outputs for the pc left applied by the previous step.
  task automatic peek(input string tag, input logic [7:0] exp_byte, input logic [4:0] exp_len);
    #1;
    chk({tag, "_byte"}, {op, imm}, exp_byte);
    chk({tag, "_len"}, {3'b0, prog_len}, {3'b0, exp_len});
  endtask

  initial begin
    // 1: reset and idle
    reset1();
    reset1();
    idle(5);

    // 2: full 16-byte load, byte n = {F-n, n}
    start();
    for (int n = 0; n < 16; n++) begin
      send(4'(n));
      send(4'(15 - n));
    end
    step(0, 0, 0, 0, 4'h0, 4'd3);
    peek("t2_pc3", 8'hC3, 5'd16);
    step(0, 0, 0, 1, 4'h5, 4'd15);  // nibble in RUN must be ignored
    peek("t2_pc15", 8'h0F, 5'd16);
    dump();

    // 3: short load ended by load_end, from a cleared memory
    reset1();
    start();
    send(4'h1); send(4'hB); send(4'h7); send(4'h3);
    finish_ld();
    step(0, 0, 0, 0, 4'h0, 4'd1);
    peek("t3_pc1", 8'h37, 5'd2);
    step(0, 0, 0, 0, 4'h0, 4'd2);
    peek("t3_pc2", 8'h00, 5'd2);
    dump();

    // 4: gappy handshake, load_end only while a low nibble is held
    start();
    for (int i = 0; i < 60; i++) begin
      bit e;
      e = m_half && ($urandom_range(0, 3) == 0);
      step(0, 0, e, 1'($urandom), 4'($urandom), 4'($urandom));
    end
    if (m_loading && m_half) send(4'($urandom));
    if (m_loading) finish_ld();
    dump();

    // 5: restart mid-byte, then start+end together
    start();
    for (int i = 0; i < 5; i++) send(4'($urandom));
    start();
    for (int i = 0; i < 4; i++) send(4'($urandom));
    step(0, 1, 1, 1, 4'($urandom), 4'($urandom));
    for (int i = 0; i < 6; i++) send(4'(i + 9));
    finish_ld();
    step(0, 0, 0, 0, 4'h0, 4'd2);
    peek("t5_pc2", 8'hED, 5'd3);
    dump();

    // 6: reset while in LOAD_HI and while in RUN
    start();
    for (int i = 0; i < 3; i++) send(4'($urandom));
    reset1();
    idle(2);
    start();
    finish_ld();
    dump();
    start();
    for (int i = 0; i < 4; i++) send(4'($urandom));
    finish_ld();
    dump();
    reset1();
    idle(2);
    start();
    finish_ld();
    dump();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
